// File: rtl/sprite_pkg.sv
// sprite_pkg: shared direction/edge-mode types, keycode defaults and helpers for sprite_mover
package sprite_pkg;

    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

    typedef enum logic [1:0] {STOP = 2'd0, BOUNCE = 2'd1, WRAP = 2'd2} edge_mode_t;

    localparam logic [7:0] KEY_UP_DEF    = 8'h1A;
    localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
    localparam logic [7:0] KEY_DOWN_DEF  = 8'h16;
    localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;

    // UP<->DOWN and LEFT<->RIGHT differ only in the low bit of the encoding
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/sprite_mover_key_to_dir.sv
// key_to_dir: combinational keycode to {valid, direction} decoder
module key_to_dir
    import sprite_pkg::*;
#(
    parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
    parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
    parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
    parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF
)(
    input  logic [7:0] keycode,
    output logic       valid,
    output dir_t       dir
);

    assign valid = keycode == KEY_UP || keycode == KEY_LEFT || keycode == KEY_DOWN || keycode == KEY_RIGHT;
    assign dir   = keycode == KEY_DOWN  ? DOWN  :
                   keycode == KEY_LEFT  ? LEFT  :
                   keycode == KEY_RIGHT ? RIGHT : UP;

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame maze sprite position engine with buffered turns and screen-edge handling
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int         W         = 10,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 639,
    parameter int         Y_MIN     = 0,
    parameter int         Y_MAX     = 479,
    parameter int         X_START   = 320,
    parameter int         Y_START   = 240,
    parameter int         SIZE      = 4,
    parameter int         STEP      = 1,
    parameter int         TILE      = 8,
    parameter edge_mode_t EDGE_MODE = STOP,
    parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
    parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
    parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
    parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF
)(
    input  logic         frame_clk,
    input  logic         Reset_n,
    input  logic [7:0]   keycode,
    input  logic         freeze,
    input  logic [3:0]   blocked,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output dir_t         dir,
    output logic         moving,
    output logic         aligned,
    output logic         bumped
);

    localparam int TB = $clog2(TILE);
    localparam logic [W-1:0] STP   = W'(STEP);
    localparam logic [W-1:0] XLO   = W'(X_MIN + SIZE);
    localparam logic [W-1:0] XHI   = W'(X_MAX - SIZE);
    localparam logic [W-1:0] YLO   = W'(Y_MIN + SIZE);
    localparam logic [W-1:0] YHI   = W'(Y_MAX - SIZE);
    // Thresholds compare the current position so pos +/- STEP never wraps through zero
    localparam logic [W-1:0] XLO_T = W'(X_MIN + SIZE + STEP);
    localparam logic [W-1:0] XHI_T = W'(X_MAX - SIZE - STEP);
    localparam logic [W-1:0] YLO_T = W'(Y_MIN + SIZE + STEP);
    localparam logic [W-1:0] YHI_T = W'(Y_MAX - SIZE - STEP);

    logic         key_valid;
    dir_t         key_dir;
    logic         pend_valid;
    dir_t         pend_dir;
    logic         take;
    logic         nm;
    logic         nb;
    dir_t         nd;
    logic [W-1:0] nx;
    logic [W-1:0] ny;

    key_to_dir #(
        .KEY_UP    (KEY_UP),
        .KEY_LEFT  (KEY_LEFT),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_RIGHT (KEY_RIGHT)
    ) u_key (
        .keycode (keycode),
        .valid   (key_valid),
        .dir     (key_dir)
    );

    assign aligned = ~|pos_x[TB-1:0] && ~|pos_y[TB-1:0];

    // Decide heading first, then step along that heading with edge handling, all in one frame
    always_comb begin
        nd   = dir;
        nm   = moving;
        nb   = 1'b0;
        take = 1'b0;
        nx   = pos_x;
        ny   = pos_y;
        if (pend_valid && pend_dir == opposite(dir)) begin
            nd   = pend_dir;
            nm   = 1'b1;
            take = 1'b1;
        end else if (aligned && pend_valid && !blocked[pend_dir]) begin
            nd   = pend_dir;
            nm   = 1'b1;
            take = 1'b1;
        end else if (aligned && blocked[dir]) begin
            nm = 1'b0;
            nb = moving;
        end
        if (nm) begin
            case (nd)
                UP:
                    if (pos_y < YLO_T) begin
                        nb = 1'b1;
                        if (EDGE_MODE == BOUNCE) begin
                            nd = DOWN;
                            ny = pos_y + STP;
                        end else begin
                            ny = YLO;
                            nm = 1'b0;
                        end
                    end else ny = pos_y - STP;
                DOWN:
                    if (pos_y > YHI_T) begin
                        nb = 1'b1;
                        if (EDGE_MODE == BOUNCE) begin
                            nd = UP;
                            ny = pos_y - STP;
                        end else begin
                            ny = YHI;
                            nm = 1'b0;
                        end
                    end else ny = pos_y + STP;
                LEFT:
                    if (pos_x < XLO_T) begin
                        if (EDGE_MODE == WRAP) nx = XHI;
                        else if (EDGE_MODE == BOUNCE) begin
                            nd = RIGHT;
                            nx = pos_x + STP;
                            nb = 1'b1;
                        end else begin
                            nx = XLO;
                            nm = 1'b0;
                            nb = 1'b1;
                        end
                    end else nx = pos_x - STP;
                default:
                    if (pos_x > XHI_T) begin
                        if (EDGE_MODE == WRAP) nx = XLO;
                        else if (EDGE_MODE == BOUNCE) begin
                            nd = LEFT;
                            nx = pos_x - STP;
                            nb = 1'b1;
                        end else begin
                            nx = XHI;
                            nm = 1'b0;
                            nb = 1'b1;
                        end
                    end else nx = pos_x + STP;
            endcase
        end
    end

    // Keep the latest mapped key as the pending turn, even when paused; applying it clears it
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_valid <= 1'b0;
            pend_dir   <= UP;
        end else if (key_valid) begin
            pend_valid <= 1'b1;
            pend_dir   <= key_dir;
        end else if (take && !freeze) pend_valid <= 1'b0;
    end

    // Motion state register; freeze holds everything and suppresses the bump pulse
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x  <= W'(X_START);
            pos_y  <= W'(Y_START);
            dir    <= LEFT;
            moving <= 1'b0;
            bumped <= 1'b0;
        end else begin
            bumped <= nb && !freeze;
            if (!freeze) begin
                pos_x  <= nx;
                pos_y  <= ny;
                dir    <= nd;
                moving <= nm;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: vector table, corner sequences and a randomized model check over all edge modes
module tb_sprite_mover;
    import sprite_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b1;
    logic       freeze    = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic [3:0] blocked   = 4'h0;
    logic [9:0] px[3];
    logic [9:0] py[3];
    dir_t       dr[3];
    logic       mv[3];
    logic       al[3];
    logic       bp[3];
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 frame_clk = ~frame_clk;

    sprite_mover #(.EDGE_MODE(STOP)) u_stop (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .freeze(freeze), .blocked(blocked),
        .pos_x(px[0]), .pos_y(py[0]), .dir(dr[0]), .moving(mv[0]), .aligned(al[0]), .bumped(bp[0]));

    sprite_mover #(.EDGE_MODE(BOUNCE)) u_bounce (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .freeze(freeze), .blocked(blocked),
        .pos_x(px[1]), .pos_y(py[1]), .dir(dr[1]), .moving(mv[1]), .aligned(al[1]), .bumped(bp[1]));

    sprite_mover #(.EDGE_MODE(WRAP)) u_wrap (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .freeze(freeze), .blocked(blocked),
        .pos_x(px[2]), .pos_y(py[2]), .dir(dr[2]), .moving(mv[2]), .aligned(al[2]), .bumped(bp[2]));

    typedef struct {
        logic [7:0] key;
        logic       frz;
        logic [3:0] blk;
        int         x;
        int         y;
        dir_t       d;
        logic       m;
        logic       b;
        logic       a;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int d;
        bit mv;
        bit pv;
        int pd;
        bit bump;
    } ms_t;

    localparam int XL = 4, XH = 635, YL = 4, YH = 475;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic state_chk(input string tag, input int i, input int x, input int y, input int d,
                             input int m, input int b);
        chk({tag, ".x"}, int'(px[i]), x);
        chk({tag, ".y"}, int'(py[i]), y);
        chk({tag, ".dir"}, int'(dr[i]), d);
        chk({tag, ".moving"}, int'(mv[i]), m);
        chk({tag, ".bumped"}, int'(bp[i]), b);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        keycode = 8'h00;
        freeze  = 1'b0;
        blocked = 4'h0;
        Reset_n = 1'b0;
        #3;
        Reset_n = 1'b1;
    endtask

    function automatic int dxf(input int d);
        return d == 2 ? -1 : d == 3 ? 1 : 0;
    endfunction

    function automatic int dyf(input int d);
        return d == 0 ? -1 : d == 1 ? 1 : 0;
    endfunction

    function automatic int oppf(input int d);
        return d == 0 ? 1 : d == 1 ? 0 : d == 2 ? 3 : 2;
    endfunction

    function automatic logic [7:0] keyf(input int d);
        return d == 0 ? 8'h1A : d == 1 ? 8'h16 : d == 2 ? 8'h04 : 8'h07;
    endfunction

    // Reference behaviour: mode 0 STOP, 1 BOUNCE, 2 WRAP
    function automatic ms_t mstep(input ms_t s, input int mode, input logic [7:0] key, input bit frz,
                                  input logic [3:0] blk);
        ms_t n;
        bit  kv, take, al_now;
        int  kd, cx, cy;
        n    = s;
        kv   = 1;
        kd   = 0;
        take = 0;
        case (key)
            8'h1A:   kd = 0;
            8'h16:   kd = 1;
            8'h04:   kd = 2;
            8'h07:   kd = 3;
            default: kv = 0;
        endcase
        n.bump = 0;
        if (!frz) begin
            al_now = (s.x % 8 == 0) && (s.y % 8 == 0);
            if (s.pv && s.pd == oppf(s.d)) begin
                n.d = s.pd; n.mv = 1; take = 1;
            end else if (al_now && s.pv && !blk[s.pd]) begin
                n.d = s.pd; n.mv = 1; take = 1;
            end else if (al_now && blk[s.d]) begin
                n.mv = 0; n.bump = s.mv;
            end
            if (n.mv) begin
                cx = s.x + dxf(n.d);
                cy = s.y + dyf(n.d);
                if (cx < XL || cx > XH) begin
                    if (mode == 2) n.x = cx < XL ? XH : XL;
                    else if (mode == 1) begin
                        n.d = oppf(n.d); n.x = s.x + dxf(n.d); n.bump = 1;
                    end else begin
                        n.x = cx < XL ? XL : XH; n.mv = 0; n.bump = 1;
                    end
                end else if (cy < YL || cy > YH) begin
                    if (mode == 1) begin
                        n.d = oppf(n.d); n.y = s.y + dyf(n.d); n.bump = 1;
                    end else begin
                        n.y = cy < YL ? YL : YH; n.mv = 0; n.bump = 1;
                    end
                end else begin
                    n.x = cx; n.y = cy;
                end
            end
        end
        if (kv) begin
            n.pv = 1; n.pd = kd;
        end else if (take && !frz) n.pv = 0;
        return n;
    endfunction

    vec_t vt[14];
    ms_t  m[3];

    initial begin
        vt = '{
            '{8'h07, 1'b0, 4'h0, 320, 240, LEFT,  1'b0, 1'b0, 1'b1},
            '{8'h00, 1'b0, 4'h0, 321, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 322, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b1, 4'h0, 322, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b1, 4'h0, 322, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b1, 4'h0, 322, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 323, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h1A, 1'b0, 4'h0, 324, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 325, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 326, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 327, 240, RIGHT, 1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 328, 240, RIGHT, 1'b1, 1'b0, 1'b1},
            '{8'h00, 1'b0, 4'h0, 328, 239, UP,    1'b1, 1'b0, 1'b0},
            '{8'h00, 1'b0, 4'h0, 328, 238, UP,    1'b1, 1'b0, 1'b0}
        };

        #1 Reset_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) state_chk($sformatf("reset%0d", i), i, 320, 240, int'(LEFT), 0, 0);
        #1 Reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            keycode = vt[i].key;
            freeze  = vt[i].frz;
            blocked = vt[i].blk;
            tick();
            state_chk($sformatf("vec%0d", i), 0, vt[i].x, vt[i].y, int'(vt[i].d), int'(vt[i].m), int'(vt[i].b));
            chk($sformatf("vec%0d.aligned", i), int'(al[0]), int'(vt[i].a));
        end

        // Wall stop at an aligned tile with a single bump pulse
        do_reset();
        keycode = 8'h07;
        tick();
        keycode = 8'h00;
        repeat (16) tick();
        chk("wall.approach_x", int'(px[0]), 336);
        blocked = 4'b1000;
        tick();
        state_chk("wall.stop", 0, 336, 240, int'(RIGHT), 0, 1);
        tick();
        state_chk("wall.hold1", 0, 336, 240, int'(RIGHT), 0, 0);
        tick();
        state_chk("wall.hold2", 0, 336, 240, int'(RIGHT), 0, 0);

        // Right screen edge in all three modes
        do_reset();
        keycode = 8'h07;
        tick();
        keycode = 8'h00;
        repeat (315) tick();
        chk("xedge.approach_x", int'(px[0]), 635);
        tick();
        state_chk("xedge.stop", 0, 635, 240, int'(RIGHT), 1'b0, 1'b1);
        state_chk("xedge.bounce", 1, 634, 240, int'(LEFT), 1'b1, 1'b1);
        state_chk("xedge.wrap", 2, 4, 240, int'(RIGHT), 1'b1, 1'b0);
        tick();
        state_chk("xedge.stop2", 0, 635, 240, int'(RIGHT), 1'b0, 1'b0);
        state_chk("xedge.bounce2", 1, 633, 240, int'(LEFT), 1'b1, 1'b0);
        state_chk("xedge.wrap2", 2, 5, 240, int'(RIGHT), 1'b1, 1'b0);

        // Bottom screen edge: bounce reverses, wrap mode stops vertically
        do_reset();
        keycode = 8'h16;
        tick();
        keycode = 8'h00;
        repeat (235) tick();
        chk("yedge.approach_y", int'(py[1]), 475);
        tick();
        state_chk("yedge.stop", 0, 320, 475, int'(DOWN), 1'b0, 1'b1);
        state_chk("yedge.bounce", 1, 320, 474, int'(UP), 1'b1, 1'b1);
        state_chk("yedge.wrap", 2, 320, 475, int'(DOWN), 1'b0, 1'b1);
        tick();
        state_chk("yedge.bounce2", 1, 320, 473, int'(UP), 1'b1, 1'b0);

        // Immediate reversal while misaligned, then asynchronous reset between edges
        do_reset();
        keycode = 8'h04;
        tick();
        keycode = 8'h00;
        tick();
        chk("rev.start_x", int'(px[0]), 319);
        repeat (17) tick();
        keycode = 8'h07;
        tick();
        state_chk("rev.before", 0, 301, 240, int'(LEFT), 1'b1, 1'b0);
        keycode = 8'h00;
        tick();
        state_chk("rev.after", 0, 302, 240, int'(RIGHT), 1'b1, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        state_chk("rev.async_reset", 0, 320, 240, int'(LEFT), 1'b0, 1'b0);
        #1 Reset_n = 1'b1;

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 3; i++) m[i] = '{320, 240, 2, 1'b0, 1'b0, 0, 1'b0};
        for (int c = 0; c < 6000; c++) begin
            int r, fav;
            fav = (c / 1000 + c / 3000) % 4;
            r   = int'($urandom_range(0, 99));
            keycode = r < 4 ? keyf(fav) : r < 6 ? keyf(int'($urandom_range(0, 3))) :
                      r < 7 ? 8'($urandom) : 8'h00;
            freeze = $urandom_range(0, 19) == 0;
            for (int b = 0; b < 4; b++) blocked[b] = $urandom_range(0, 15) == 0;
            tick();
            for (int i = 0; i < 3; i++) begin
                m[i] = mstep(m[i], i, keycode, freeze, blocked);
                n_chk++;
                if (int'(px[i]) != m[i].x || int'(py[i]) != m[i].y || int'(dr[i]) != m[i].d ||
                    mv[i] != m[i].mv || bp[i] != m[i].bump ||
                    al[i] != ((m[i].x % 8 == 0) && (m[i].y % 8 == 0))) begin
                    n_fail++;
                    $display("FAIL rand c%0d mode%0d: got x=%0d y=%0d d=%0d m=%0d b=%0d expected x=%0d y=%0d d=%0d m=%0d b=%0d",
                             c, i, px[i], py[i], dr[i], mv[i], bp[i], m[i].x, m[i].y, m[i].d, m[i].mv, m[i].bump);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
